paddle_array: RTL
=================

// Module: paddle_array
// PURPOSE
//  Multi-channel analog-controller front end: per channel, selects paddle, analog stick or the shared PS/2 mouse as
//  the source of one POT value and one fire button, feeding the console paddle/pot inputs. Generalises the single-
//  channel controller to NUM_CH channels, wider output, routable mouse, tunable mouse gain and an optional slew limiter.
// PARAMETERS
//  NUM_CH      4    number of paddle channels (1..8)
//  OUT_W       8    a_out width per channel (8..16); value = 8-bit two's-complement << (OUT_W-8)
//  MOUSE_SHIFT 1    mouse delta arithmetic right shift (gain divider)
//  MOUSE_STEP  10   max |delta| applied per mouse packet
//  STICK_THR   100  stick axis magnitude (positive side) that selects that axis
//  SLEW        0    max change per tick in 8-bit units; 0 = limiter bypassed
// PORTS
//  clk_sys     in   1            system clock
//  reset       in   1            synchronous, active-high
//  inv         in   1            invert all analog outputs
//  mouse_ch    in   3            channel that owns the mouse
//  tick        in   1            slew update strobe (ignored when SLEW=0)
//  stick_btn   in   NUM_CH       per-channel stick-mode button, also fire in stick mode
//  paddle_btn  in   NUM_CH       per-channel paddle-mode button, also fire in paddle mode
//  joy_a       in   NUM_CH*16    per channel {Y[7:0],X[7:0]} signed stick axes
//  paddle      in   NUM_CH*8     per channel unsigned paddle position
//  ps2_mouse   in   25           [24] toggle strobe, [23:16] dY, [15:8] dX, [5] Ysign, [4] Xsign, [1:0] R/L btn
//  b_out       out  NUM_CH       per-channel fire
//  a_out       out  NUM_CH*OUT_W per-channel pot value
// BEHAVIOUR
//  Reset: src[i]=PADDLE, xy[i]=0, mouse acc X/Y=0, target=0, a_out=0, b_out=0; old_stb <= ps2_mouse[24].
//  Strobe = ps2_mouse[24] != old_stb. On strobe, channel mouse_ch -> MOUSE; mouse_ch>=NUM_CH: strobe ignored.
//  Source priority per channel, same cycle: paddle_btn -> PADDLE > stick_btn -> STICK > strobe -> MOUSE.
//  mouse_ch change: acc X/Y cleared; previous owner, if MOUSE, reverts to PADDLE in the same cycle.
//  Mouse delta: 9-bit signed {sign,byte} >>> MOUSE_SHIFT, clamped to +/-MOUSE_STEP; acc += delta,
//   saturated to [-128,127]; one update per strobe.
//  Axis select, latched in xy[i]: MOUSE: R btn -> Y, L btn -> X (L wins if both);
//   STICK: Y>=0 and Y>STICK_THR -> Y, same on X -> X (X wins). Held in PADDLE.
//  Target (8-bit, registered): PADDLE {~p[7],p[6:0]}; STICK xy?Y:X; MOUSE xy?accY:accX; inv -> bitwise ~.
//  SLEW=0: a_out = target << (OUT_W-8), registered; input-to-a_out latency 2 cycles.
//  SLEW>0: per tick, out moves toward target by min(|diff|,SLEW), signed compare, no overshoot, no wrap.
//   Source change on a channel snaps out to the new target at once (no slew).
//  b_out (1-cycle latency): PADDLE paddle_btn[i]; STICK stick_btn[i]; MOUSE |ps2_mouse[1:0].
//  Non-owner channels ignore mouse buttons and strobes. Reset mid-update wins over all events that cycle.
// STRUCTURE
//  Package paddle_pkg: src_t enum {SRC_PADDLE=0, SRC_STICK=1, SRC_MOUSE=2}; sat8/clamp helper functions.
//  Sub-module paddle_slew (target, tick, snap -> out), one instance per channel via generate; source select,
//  mouse accumulator and axis latches in the top.
// TESTING
//  Reset, paddle[0]=8'h00 -> a_out[0]=8'h80 after 2 cycles; inv=1 -> 8'h7F; b_out follows paddle_btn[0].
//  stick_btn[1] pulse, joy_a[1]={8'd110,8'd5} -> xy=Y, a_out[1]=110; then X=120 -> X selected, a_out=120.
//  mouse_ch=2, 20 strobes with dX=+40, MOUSE_SHIFT=1 -> +10 each, saturates at 127; dX=-40 x30 -> -128.
//  Strobe and paddle_btn[2] same cycle -> ch2 stays PADDLE; mouse_ch 2->3 -> acc=0, ch2 PADDLE.
//  SLEW=4, target 0->20 -> out 4,8,12,16,20 on ticks; no change without tick; stick_btn -> immediate snap.
//  OUT_W=10, target 8'h7F -> a_out=10'h1FC; reset mid-slew -> all outputs 0 next cycle.

Source files
------------

// File: rtl/paddle_pkg.sv
// Shared types and arithmetic helpers for the paddle_array controller front end.
package paddle_pkg;

    typedef enum logic [1:0] {
        SRC_PADDLE = 2'd0,
        SRC_STICK  = 2'd1,
        SRC_MOUSE  = 2'd2
    } src_t;

    // Saturate a widened signed sum back into the signed 8-bit range.
    function automatic logic [7:0] sat8(input logic signed [9:0] v);
        logic [7:0] r;
        if (v > 10'sd127) begin
            r = 8'h7F;
        end else if (v < -10'sd128) begin
            r = 8'h80;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

    function automatic logic signed [8:0] clamp9(input logic signed [8:0] v, input int lim);
        logic signed [8:0] r;
        if (int'(v) > lim) begin
            r = 9'(lim);
        end else if (int'(v) < -lim) begin
            r = 9'(-lim);
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/paddle_slew.sv
// Per-channel output stage: optional slew limiter between the registered target and a_out.
module paddle_slew
    import paddle_pkg::*;
#(
    parameter int OUT_W = 8,
    parameter int SLEW  = 0
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [7:0]       target_i,
    input  logic             tick_i,
    input  logic             snap_i,
    output logic [OUT_W-1:0] out_o
);
    localparam logic signed [9:0] STEP = 10'(SLEW);

    logic [7:0]        out_q;
    logic [7:0]        out_d;
    logic signed [9:0] diff;

    // Values are two's complement, so the distance is taken on sign-extended operands.
    always_comb begin
        diff  = $signed({{2{target_i[7]}}, target_i}) - $signed({{2{out_q[7]}}, out_q});
        out_d = out_q;
        if (SLEW == 0 || snap_i) begin
            out_d = target_i;
        end else if (tick_i) begin
            if (diff > STEP) begin
                out_d = out_q + STEP[7:0];
            end else if (diff < -STEP) begin
                out_d = out_q - STEP[7:0];
            end else begin
                out_d = target_i;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            out_q <= 8'h00;
        end else begin
            out_q <= out_d;
        end
    end

    assign out_o = OUT_W'(out_q) << (OUT_W - 8);

endmodule

// File: rtl/paddle_array.sv
// Multi-channel paddle / stick / mouse selector driving per-channel pot values and fire buttons.
module paddle_array
    import paddle_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int OUT_W       = 8,
    parameter int MOUSE_SHIFT = 1,
    parameter int MOUSE_STEP  = 10,
    parameter int STICK_THR   = 100,
    parameter int SLEW        = 0
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic                    inv,
    input  logic [2:0]              mouse_ch,
    input  logic                    tick,
    input  logic [NUM_CH-1:0]       stick_btn,
    input  logic [NUM_CH-1:0]       paddle_btn,
    input  logic [NUM_CH*16-1:0]    joy_a,
    input  logic [NUM_CH*8-1:0]     paddle,
    input  logic [24:0]             ps2_mouse,
    output logic [NUM_CH-1:0]       b_out,
    output logic [NUM_CH*OUT_W-1:0] a_out
);
    localparam logic signed [8:0] THR = 9'(STICK_THR);

    logic              old_stb_q;
    logic [2:0]        mouse_ch_q;
    logic [7:0]        acc_x_q, acc_x_d;
    logic [7:0]        acc_y_q, acc_y_d;
    logic              strobe;
    logic              ch_change;
    logic              mouse_valid;
    logic signed [8:0] raw_dx, raw_dy;
    logic signed [8:0] dx, dy;
    logic              unused_bits;

    assign strobe      = ps2_mouse[24] != old_stb_q;
    assign ch_change   = mouse_ch != mouse_ch_q;
    assign mouse_valid = {1'b0, mouse_ch} < 4'(NUM_CH);
    assign raw_dx      = $signed({ps2_mouse[4], ps2_mouse[15:8]}) >>> MOUSE_SHIFT;
    assign raw_dy      = $signed({ps2_mouse[5], ps2_mouse[23:16]}) >>> MOUSE_SHIFT;
    assign dx          = clamp9(raw_dx, MOUSE_STEP);
    assign dy          = clamp9(raw_dy, MOUSE_STEP);
    assign unused_bits = &{1'b0, ps2_mouse[7:6], ps2_mouse[3:2]};

    // A change of mouse owner restarts the accumulators; that cycle's packet is dropped.
    always_comb begin
        acc_x_d = acc_x_q;
        acc_y_d = acc_y_q;
        if (ch_change) begin
            acc_x_d = 8'h00;
            acc_y_d = 8'h00;
        end else if (strobe && mouse_valid) begin
            acc_x_d = sat8($signed({{2{acc_x_q[7]}}, acc_x_q}) + $signed({dx[8], dx}));
            acc_y_d = sat8($signed({{2{acc_y_q[7]}}, acc_y_q}) + $signed({dy[8], dy}));
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            old_stb_q  <= ps2_mouse[24];
            mouse_ch_q <= mouse_ch;
            acc_x_q    <= 8'h00;
            acc_y_q    <= 8'h00;
        end else begin
            old_stb_q  <= ps2_mouse[24];
            mouse_ch_q <= mouse_ch;
            acc_x_q    <= acc_x_d;
            acc_y_q    <= acc_y_d;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        src_t       src_q, src_d;
        logic       xy_q, xy_d;
        logic [7:0] target_q, target_d;
        logic       snap_q;
        logic       b_q, b_d;
        logic       owner;
        logic [7:0] joy_x, joy_y, pad, raw;

        assign owner = mouse_ch == 3'(gi);
        assign joy_x = joy_a[gi*16 +: 8];
        assign joy_y = joy_a[gi*16+8 +: 8];
        assign pad   = paddle[gi*8 +: 8];

        always_ff @(posedge clk_sys) begin
            if (reset) begin
                src_q    <= SRC_PADDLE;
                xy_q     <= 1'b0;
                target_q <= 8'h00;
                snap_q   <= 1'b0;
                b_q      <= 1'b0;
            end else begin
                src_q    <= src_d;
                xy_q     <= xy_d;
                target_q <= target_d;
                snap_q   <= src_d != src_q;
                b_q      <= b_d;
            end
        end

        // Later assignments override earlier ones: paddle > stick > mouse strobe > hold.
        always_comb begin
            src_d = src_q;
            if (ch_change && mouse_ch_q == 3'(gi) && src_q == SRC_MOUSE) begin
                src_d = SRC_PADDLE;
            end
            if (strobe && owner) begin
                src_d = SRC_MOUSE;
            end
            if (stick_btn[gi]) begin
                src_d = SRC_STICK;
            end
            if (paddle_btn[gi]) begin
                src_d = SRC_PADDLE;
            end

            xy_d = xy_q;
            if (src_d == SRC_MOUSE && owner) begin
                if (ps2_mouse[0]) begin
                    xy_d = 1'b0;
                end else if (ps2_mouse[1]) begin
                    xy_d = 1'b1;
                end
            end else if (src_d == SRC_STICK) begin
                if (!joy_x[7] && $signed({1'b0, joy_x}) > THR) begin
                    xy_d = 1'b0;
                end else if (!joy_y[7] && $signed({1'b0, joy_y}) > THR) begin
                    xy_d = 1'b1;
                end
            end
        end

        always_comb begin
            case (src_d)
                SRC_STICK: raw = xy_d ? joy_y : joy_x;
                SRC_MOUSE: raw = xy_d ? acc_y_d : acc_x_d;
                default:   raw = {~pad[7], pad[6:0]};
            endcase
            target_d = inv ? ~raw : raw;

            case (src_d)
                SRC_STICK: b_d = stick_btn[gi];
                SRC_MOUSE: b_d = owner && (|ps2_mouse[1:0]);
                default:   b_d = paddle_btn[gi];
            endcase
        end

        paddle_slew #(
            .OUT_W (OUT_W),
            .SLEW  (SLEW)
        ) u_slew (
            .clk_sys  (clk_sys),
            .reset    (reset),
            .target_i (target_q),
            .tick_i   (tick),
            .snap_i   (snap_q),
            .out_o    (a_out[gi*OUT_W +: OUT_W])
        );

        assign b_out[gi] = b_q;
    end

endmodule
